ctrl_pipe: RTL

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe_pkg.sv | 20 ++
 rtl/ctrl_stage.sv | 47 ++++
 rtl/ctrl_pipe.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared types and defaults for the control-bundle pipeline.
// Latency: n/a (types, parameters and a width helper only).
// Backpressure: n/a.
package ctrl_pipe_pkg;

  localparam int DEF_W      = 17;
  localparam int DEF_NSTG   = 3;
  localparam int DEF_MC_LAT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

  // Residency counter width; never narrower than one bit.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/ctrl_stage.sv
// One pipeline register stage: control bundle, valid and multicycle flag.
// Latency: 1 cycle from input to output on advance.
// Backpressure: flush clears, hold retains, bubble loads an empty slot.
module ctrl_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic         bubble,
  input  logic         in_valid,
  input  logic [W-1:0] in_ctrl,
  input  logic         in_mc,
  output logic         valid,
  output logic [W-1:0] ctrl,
  output logic         mc
);

  // Flush beats hold beats advance; a bubble is an advance of an empty slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      mc    <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
      mc    <= 1'b0;
    end else if (hold) begin
      valid <= valid;
      ctrl  <= ctrl;
      mc    <= mc;
    end else if (bubble) begin
      valid <= 1'b0;
      ctrl  <= '0;
      mc    <= 1'b0;
    end else begin
      valid <= in_valid;
      ctrl  <= in_ctrl;
      mc    <= in_mc;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Decode-to-writeback control pipeline with per-stage stall/flush and a multicycle hold FSM.
// Latency: decode to stage k is k+1 cycles; multicycle bundles sit in stage 0 for MC_LAT cycles.
// Backpressure: a stall on stage k holds stages 0..k, bubbles k+1, and raises stall_req_o to decode.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int NSTG   = DEF_NSTG,
  parameter int MC_LAT = DEF_MC_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    ctrl_d,
  input  logic            valid_d,
  input  logic            mc_d,
  input  logic [NSTG-1:0] stall_i,
  input  logic [NSTG-1:0] flush_i,
  output logic [NSTG*W-1:0] ctrl_o,
  output logic [NSTG-1:0] valid_o,
  output logic            busy_o,
  output logic            stall_req_o
);

  localparam int            CW       = cnt_width(MC_LAT);
  localparam bit            MC_EN    = (MC_LAT > 1);
  localparam logic [CW-1:0] CNT_INIT = CW'((MC_LAT > 1) ? (MC_LAT - 2) : 0);

  mc_state_t       state;
  logic [CW-1:0]   cnt;
  logic [NSTG-1:0] h;
  logic [NSTG-1:0] stg_valid;
  logic [NSTG-1:0] stg_mc;
  logic [W-1:0]    stg_ctrl [NSTG];
  logic            start_mc;

  assign busy_o      = (state == BUSY);
  assign stall_req_o = h[0];
  assign valid_o     = stg_valid;

  // Hold propagates upstream: a stalled stage freezes every older stage; busy freezes stage 0.
  always_comb begin
    logic acc;
    acc = 1'b0;
    h   = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      acc  = acc | stall_i[k];
      h[k] = acc;
    end
    h[0] = h[0] | busy_o;
  end

  // Multicycle entry only when stage 0 actually captures a fresh valid multicycle bundle.
  assign start_mc = MC_EN && !flush_i[0] && !h[0] && valid_d && mc_d;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic         in_valid;
    logic [W-1:0] in_ctrl;
    logic         in_mc;
    logic         bubble;

    if (k == 0) begin : g_head
      assign in_valid = valid_d;
      assign in_ctrl  = ctrl_d;
      assign in_mc    = mc_d;
      assign bubble   = 1'b0;
    end else begin : g_body
      // The mc flag lives only in stage 0; downstream copies are tied off.
      assign in_valid = stg_valid[k-1];
      assign in_ctrl  = stg_ctrl[k-1];
      assign in_mc    = 1'b0;
      assign bubble   = h[k-1];
    end

    ctrl_stage #(.W(W)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush_i[k]),
      .hold     (h[k]),
      .bubble   (bubble),
      .in_valid (in_valid),
      .in_ctrl  (in_ctrl),
      .in_mc    (in_mc),
      .valid    (stg_valid[k]),
      .ctrl     (stg_ctrl[k]),
      .mc       (stg_mc[k])
    );

    assign ctrl_o[k*W +: W] = stg_ctrl[k];
  end

  // Residency FSM: the entry cycle counts as the first of MC_LAT, flush on stage 0 aborts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_mc) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (flush_i[0]) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // While busy, stage 0 must still be holding the valid multicycle bundle that started it.
  a_busy_owns_stage0: assert property (@(posedge clk) disable iff (!rst)
    (state == BUSY) |-> (stg_mc[0] && stg_valid[0]));

  // Only stage 0 ever carries the multicycle flag.
  a_mc_stage0_only: assert property (@(posedge clk) disable iff (!rst)
    ((stg_mc >> 1) == '0));

endmodule
